// File: rtl/ref_window_buf_pkg.sv
// Shared defaults, read-mode constants and the row type for the reference window buffer.
package ref_win_pkg;

  localparam int unsigned PIXEL = 8;
  localparam int unsigned X     = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NROW  = 8;

  localparam logic RD_SINGLE = 1'b0;
  localparam logic RD_MULTI  = 1'b1;

  typedef logic [X*PIXEL-1:0] row_t;

endpackage

// File: rtl/ref_window_buf_if.sv
// Write/read handshake bundle between reference fetch, window buffer and PE array.
interface ref_window_buf_if
  import ref_win_pkg::*;
#(
  parameter int unsigned PIXEL = ref_win_pkg::PIXEL,
  parameter int unsigned X     = ref_win_pkg::X,
  parameter int unsigned DEPTH = ref_win_pkg::DEPTH,
  parameter int unsigned NROW  = ref_win_pkg::NROW
) ();

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(X);

  logic                    wr_vld;
  logic [X*PIXEL-1:0]      wr_data;
  logic                    wr_rdy;
  logic                    rd_en;
  logic                    rd_mode;
  logic [AW-1:0]           rd_addr;
  logic [CW-1:0]           rd_col_off;
  logic                    rd_release;
  logic                    bank_rdy;
  logic [NROW*X*PIXEL-1:0] rd_data;
  logic                    rd_vld_multi;
  logic                    rd_vld_single;
  logic                    rd_err;

  modport master (
    output wr_vld, wr_data, rd_en, rd_mode, rd_addr, rd_col_off, rd_release,
    input  wr_rdy, bank_rdy, rd_data, rd_vld_multi, rd_vld_single, rd_err
  );

  modport slave (
    input  wr_vld, wr_data, rd_en, rd_mode, rd_addr, rd_col_off, rd_release,
    output wr_rdy, bank_rdy, rd_data, rd_vld_multi, rd_vld_single, rd_err
  );

endinterface

// File: rtl/ref_window_buf_rotator.sv
// Combinational horizontal rotation of one row: out pixel j = in pixel (j+col_off) mod X.
module ref_row_rotator
  import ref_win_pkg::*;
#(
  parameter int unsigned PIXEL = ref_win_pkg::PIXEL,
  parameter int unsigned X     = ref_win_pkg::X
) (
  input  logic [X*PIXEL-1:0]     row_in,
  input  logic [$clog2(X)-1:0]   col_off,
  output logic [X*PIXEL-1:0]     row_out
);

  // Gather each output pixel from its rotated source position.
  always_comb begin
    row_out = '0;
    for (int unsigned j = 0; j < X; j++) begin
      row_out[j*PIXEL +: PIXEL] = row_in[((j + 32'(col_off)) % X)*PIXEL +: PIXEL];
    end
  end

endmodule

// File: rtl/ref_window_buf.sv
// Ping-pong reference window memory: one bank filled row by row while the other is read
// as one row or NROW consecutive rows (wrapping inside the bank), with pixel rotation.
module ref_window_buf
  import ref_win_pkg::*;
#(
  parameter int unsigned PIXEL = ref_win_pkg::PIXEL,
  parameter int unsigned X     = ref_win_pkg::X,
  parameter int unsigned DEPTH = ref_win_pkg::DEPTH,
  parameter int unsigned NROW  = ref_win_pkg::NROW
) (
  input  logic             clk,
  input  logic             rst_n,
  ref_window_buf_if.slave  bus
);

  localparam int unsigned RW = X*PIXEL;
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    bank_full;

  logic [RW-1:0] mem [2*DEPTH];

  logic          wr_rdy;
  logic          bank_rdy;
  logic          wr_acc;
  logic          rd_acc;

  logic [RW-1:0] raw_row [NROW];
  logic [RW-1:0] rot_row [NROW];

  logic [NROW*RW-1:0] rd_data_q;
  logic               rd_vld_multi_q;
  logic               rd_vld_single_q;
  logic               rd_err_q;

  assign wr_rdy   = ~bank_full[wr_bank];
  assign bank_rdy = bank_full[rd_bank];
  assign wr_acc   = bus.wr_vld & wr_rdy;
  assign rd_acc   = bus.rd_en & bank_rdy;

  assign bus.wr_rdy        = wr_rdy;
  assign bus.bank_rdy      = bank_rdy;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_vld_multi  = rd_vld_multi_q;
  assign bus.rd_vld_single = rd_vld_single_q;
  assign bus.rd_err        = rd_err_q;

  // Bank ownership and write pointer; a final write beat and a release always
  // target different banks, so both updates can land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_ptr    <= '0;
      bank_full <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == AW'(DEPTH-1)) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
        end
      end
      if (bus.rd_release && bank_rdy) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end

  // Row storage, indexed {bank, row}; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_bank, wr_ptr}] <= bus.wr_data;
    end
  end

  // Select NROW consecutive rows from the read bank; single-row mode keeps row 0 only.
  always_comb begin
    for (int unsigned k = 0; k < NROW; k++) begin
      raw_row[k] = mem[{rd_bank, AW'(bus.rd_addr + AW'(k))}];
      if (bus.rd_mode == RD_SINGLE && k != 0) begin
        raw_row[k] = '0;
      end
    end
  end

  for (genvar g = 0; g < NROW; g++) begin : g_rot
    ref_row_rotator #(
      .PIXEL (PIXEL),
      .X     (X)
    ) u_rot (
      .row_in  (raw_row[g]),
      .col_off (bus.rd_col_off),
      .row_out (rot_row[g])
    );
  end

  // Registered read result and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q       <= '0;
      rd_vld_multi_q  <= 1'b0;
      rd_vld_single_q <= 1'b0;
      rd_err_q        <= 1'b0;
    end else begin
      rd_vld_multi_q  <= rd_acc & (bus.rd_mode == RD_MULTI);
      rd_vld_single_q <= rd_acc & (bus.rd_mode == RD_SINGLE);
      rd_err_q        <= bus.rd_en & ~bank_rdy;
      if (rd_acc) begin
        for (int unsigned k = 0; k < NROW; k++) begin
          rd_data_q[k*RW +: RW] <= rot_row[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_ref_window_buf.sv
// Directed self-checking bench for ref_window_buf.
module tb_ref_window_buf;
  import ref_win_pkg::*;

  localparam int unsigned RW = X*PIXEL;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(X);

  typedef logic [NROW*RW-1:0] win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ref_window_buf_if #(.PIXEL(PIXEL), .X(X), .DEPTH(DEPTH), .NROW(NROW)) bus ();

  ref_window_buf #(.PIXEL(PIXEL), .X(X), .DEPTH(DEPTH), .NROW(NROW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  win_t exp_last = '0;

  function automatic row_t fill_row(input logic [7:0] v);
    return {X{v}};
  endfunction

  function automatic row_t ramp_row(input int unsigned off);
    row_t r;
    r = '0;
    for (int unsigned j = 0; j < X; j++) r[j*PIXEL +: PIXEL] = 8'((j + off) % X);
    return r;
  endfunction

  function automatic int first_diff(input win_t a, input win_t b);
    for (int k = 0; k < int'(NROW); k++) if (a[k*RW +: RW] !== b[k*RW +: RW]) return k;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_vld = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.rd_mode = RD_SINGLE;
    bus.rd_addr = '0; bus.rd_col_off = '0; bus.rd_release = 1'b0;
  endtask

  // n beats; beat i carries {X{base+i}}, or a ramp on beat 0 when ramp0 is set.
  task automatic write_beats(input int n, input logic [7:0] base, input bit ramp0);
    for (int i = 0; i < n; i++) begin
      bus.wr_vld  = 1'b1;
      bus.wr_data = (ramp0 && i == 0) ? ramp_row(0) : fill_row(base + 8'(i));
      step();
    end
    bus.wr_vld = 1'b0;
  endtask

  task automatic do_read(input logic mode, input logic [AW-1:0] addr,
                         input logic [CW-1:0] off, input logic rel);
    bus.rd_en = 1'b1; bus.rd_mode = mode; bus.rd_addr = addr;
    bus.rd_col_off = off; bus.rd_release = rel;
    step();
    bus.rd_en = 1'b0; bus.rd_release = 1'b0; bus.rd_col_off = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    checks++; if (bus.wr_rdy !== 1'b1) begin failures++; $display("FAIL reset_wr_rdy got=%b exp=1", bus.wr_rdy); end
    checks++; if (bus.bank_rdy !== 1'b0) begin failures++; $display("FAIL reset_bank_rdy got=%b exp=0", bus.bank_rdy); end
    checks++; if (bus.rd_data !== win_t'(0)) begin failures++; $display("FAIL reset_rd_data row0 got=%h exp=0", bus.rd_data[RW-1:0]); end
    checks++; if ({bus.rd_vld_multi, bus.rd_vld_single, bus.rd_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.rd_vld_multi, bus.rd_vld_single, bus.rd_err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_multi();
    win_t e;
    int   k;
    write_beats(63, 8'h00, 1'b0);
    checks++; if (bus.bank_rdy !== 1'b0) begin failures++; $display("FAIL fill63_bank_rdy got=%b exp=0", bus.bank_rdy); end
    write_beats(1, 8'd63, 1'b0);
    checks++; if (bus.bank_rdy !== 1'b1) begin failures++; $display("FAIL fill64_bank_rdy got=%b exp=1", bus.bank_rdy); end
    checks++; if (bus.wr_rdy !== 1'b1) begin failures++; $display("FAIL fill64_wr_rdy got=%b exp=1", bus.wr_rdy); end
    do_read(RD_MULTI, AW'(5), '0, 1'b0);
    e = '0;
    for (int r = 0; r < int'(NROW); r++) e[r*RW +: RW] = fill_row(8'(5 + r));
    exp_last = e;
    checks++; if ({bus.rd_vld_multi, bus.rd_vld_single, bus.rd_err} !== 3'b100) begin
      failures++; $display("FAIL multi5_flags got=%b exp=100", {bus.rd_vld_multi, bus.rd_vld_single, bus.rd_err}); end
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL multi5_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
    step();
    checks++; if (bus.rd_vld_multi !== 1'b0) begin failures++; $display("FAIL multi5_pulse got=%b exp=0", bus.rd_vld_multi); end
    checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL multi5_hold row0 got=%h exp=%h", bus.rd_data[RW-1:0], e[RW-1:0]); end
  endtask

  task automatic test_wrap_single();
    win_t e;
    int   k;
    do_read(RD_MULTI, AW'(60), '0, 1'b0);
    e = '0;
    for (int r = 0; r < int'(NROW); r++) e[r*RW +: RW] = fill_row(8'((60 + r) % 64));
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL wrap60_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
    do_read(RD_SINGLE, AW'(7), '0, 1'b0);
    e = '0;
    e[RW-1:0] = fill_row(8'h07);
    exp_last = e;
    checks++; if ({bus.rd_vld_multi, bus.rd_vld_single} !== 2'b01) begin
      failures++; $display("FAIL single7_flags got=%b exp=01", {bus.rd_vld_multi, bus.rd_vld_single}); end
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL single7_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
  endtask

  task automatic test_ping_pong();
    win_t e;
    int   k;
    write_beats(64, 8'h40, 1'b1);
    checks++; if (bus.wr_rdy !== 1'b0) begin failures++; $display("FAIL both_full_wr_rdy got=%b exp=0", bus.wr_rdy); end
    bus.wr_vld = 1'b1; bus.wr_data = fill_row(8'hEE);
    step();
    bus.wr_vld = 1'b0;
    checks++; if (bus.wr_rdy !== 1'b0) begin failures++; $display("FAIL drop_wr_rdy got=%b exp=0", bus.wr_rdy); end
    do_read(RD_SINGLE, AW'(0), '0, 1'b0);
    e = '0;
    e[RW-1:0] = fill_row(8'h00);
    checks++; if (bus.rd_data !== e) begin failures++; $display("FAIL drop_row0 got=%h exp=%h", bus.rd_data[RW-1:0], e[RW-1:0]); end
    // Read bank0 and release it in the same cycle: data must still come from bank0.
    do_read(RD_MULTI, AW'(9), '0, 1'b1);
    e = '0;
    for (int r = 0; r < int'(NROW); r++) e[r*RW +: RW] = fill_row(8'(9 + r));
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL rel_read_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
    checks++; if (bus.bank_rdy !== 1'b1) begin failures++; $display("FAIL rel_bank_rdy got=%b exp=1", bus.bank_rdy); end
    checks++; if (bus.wr_rdy !== 1'b1) begin failures++; $display("FAIL rel_wr_rdy got=%b exp=1", bus.wr_rdy); end
    do_read(RD_MULTI, AW'(1), '0, 1'b0);
    e = '0;
    for (int r = 0; r < int'(NROW); r++) e[r*RW +: RW] = fill_row(8'(8'h41 + r));
    exp_last = e;
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL bank1_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
  endtask

  task automatic test_rotation();
    win_t e;
    int   k;
    do_read(RD_SINGLE, AW'(0), CW'(3), 1'b0);
    checks++; if (bus.rd_data[PIXEL-1:0] !== 8'd3) begin failures++; $display("FAIL rot3_pix0 got=%0d exp=3", bus.rd_data[PIXEL-1:0]); end
    checks++; if (bus.rd_data[(X-1)*PIXEL +: PIXEL] !== 8'd2) begin
      failures++; $display("FAIL rot3_pix31 got=%0d exp=2", bus.rd_data[(X-1)*PIXEL +: PIXEL]); end
    e = '0;
    e[RW-1:0] = ramp_row(3);
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL rot3_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
    do_read(RD_MULTI, AW'(62), CW'(1), 1'b0);
    e = '0;
    e[0*RW +: RW] = fill_row(8'h7E);
    e[1*RW +: RW] = fill_row(8'h7F);
    e[2*RW +: RW] = ramp_row(1);
    for (int r = 3; r < int'(NROW); r++) e[r*RW +: RW] = fill_row(8'(8'h41 + r - 3));
    exp_last = e;
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL rot1_wrap_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
  endtask

  task automatic test_errors_reset();
    win_t e;
    int   k;
    bus.rd_release = 1'b1;
    step();
    bus.rd_release = 1'b0;
    checks++; if (bus.bank_rdy !== 1'b0) begin failures++; $display("FAIL rel1_bank_rdy got=%b exp=0", bus.bank_rdy); end
    do_read(RD_MULTI, AW'(0), '0, 1'b0);
    checks++; if ({bus.rd_vld_multi, bus.rd_vld_single, bus.rd_err} !== 3'b001) begin
      failures++; $display("FAIL err_flags got=%b exp=001", {bus.rd_vld_multi, bus.rd_vld_single, bus.rd_err}); end
    checks++; if (bus.rd_data !== exp_last) begin
      failures++; k = first_diff(bus.rd_data, exp_last);
      $display("FAIL err_hold row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], exp_last[k*RW +: RW]); end
    step();
    checks++; if (bus.rd_err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", bus.rd_err); end
    // Abort a load at beat 30 with reset; a full bank must then take exactly 64 fresh beats.
    write_beats(30, 8'h80, 1'b0);
    bus.wr_vld = 1'b1; bus.wr_data = fill_row(8'h9E);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.wr_vld = 1'b0;
    checks++; if ({bus.wr_rdy, bus.bank_rdy} !== 2'b10) begin
      failures++; $display("FAIL midreset_rdy got=%b exp=10", {bus.wr_rdy, bus.bank_rdy}); end
    checks++; if (bus.rd_data !== win_t'(0)) begin failures++; $display("FAIL midreset_rd_data row0 got=%h exp=0", bus.rd_data[RW-1:0]); end
    write_beats(63, 8'hA0, 1'b0);
    checks++; if (bus.bank_rdy !== 1'b0) begin failures++; $display("FAIL refill63_bank_rdy got=%b exp=0", bus.bank_rdy); end
    write_beats(1, 8'hDF, 1'b0);
    checks++; if (bus.bank_rdy !== 1'b1) begin failures++; $display("FAIL refill64_bank_rdy got=%b exp=1", bus.bank_rdy); end
    do_read(RD_MULTI, AW'(0), '0, 1'b0);
    e = '0;
    for (int r = 0; r < int'(NROW); r++) e[r*RW +: RW] = fill_row(8'(8'hA0 + r));
    checks++; if (bus.rd_data !== e) begin
      failures++; k = first_diff(bus.rd_data, e);
      $display("FAIL refill_data row%0d got=%h exp=%h", k, bus.rd_data[k*RW +: RW], e[k*RW +: RW]); end
  endtask

  initial begin
    test_reset();
    test_fill_multi();
    test_wrap_single();
    test_ping_pong();
    test_rotation();
    test_errors_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
